mcpu_registerfile_mp: RTL
=========================

MCPU_REGISTERFILE_MP -- requirements
Module: mcpu_registerfile_mp

Interface
REQ-001 Parameters SHALL be: WORD_SIZE, 16, data width; REGS_NUMBER_WIDTH, 4, address width; REGISTERS_NUMBER, 1<<REGS_NUMBER_WIDTH, register count (derived, not overridden); RESET_VALUE, 0, reset content of every register.
REQ-002 Ports SHALL be, in this order:
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 op1  input  REGS_NUMBER_WIDTH  destination/write address; also read address for regop.
REQ-006 op2  input  REGS_NUMBER_WIDTH  read address for alu1.
REQ-007 op3  input  REGS_NUMBER_WIDTH  read address for alu2.
REQ-008 datatoload  input  WORD_SIZE  write operand.
REQ-009 regsetwb  input  1  write-back strobe, sampled on rising clk.
REQ-010 regsetcmd  input  2  write command, valid when regsetwb=1.
REQ-011 dirty_clr  input  1  clears whole dirty mask.
REQ-012 regop  output  WORD_SIZE  content of register op1.
REQ-013 alu1  output  WORD_SIZE  content of register op2.
REQ-014 alu2  output  WORD_SIZE  content of register op3.
REQ-015 dirty  output  REGISTERS_NUMBER  bit i set = register i written since last clear.
REQ-016 wb_ack  output  1  one-cycle pulse acknowledging a completed write.
REQ-017 carry  output  1  carry-out of last arithmetic write command.

Function
REQ-018 Read ports SHALL be combinational from register array; three reads, any address aliasing allowed.
REQ-019 On rising clk with regsetwb=1, register op1 SHALL be updated per regsetcmd: 00 load datatoload; 01 clear to 0; 10 increment by 1; 11 accumulate reg+datatoload.
REQ-020 Arithmetic SHALL be modulo 2^WORD_SIZE (wrap-around); carry SHALL capture bit WORD_SIZE of the sum for commands 10/11, SHALL be cleared by 00/01, SHALL hold when regsetwb=0.
REQ-021 regsetwb=0 SHALL leave array, carry and dirty (except dirty_clr) unchanged; op/data inputs ignored.
REQ-022 wb_ack SHALL be 1 in the cycle after each edge that performed a write, 0 otherwise; back-to-back writes SHALL keep wb_ack high continuously.
REQ-023 Write latency SHALL be one edge: new value visible on read ports after the writing edge.
REQ-024 Each write SHALL set dirty[op1]; dirty_clr=1 SHALL clear all bits at the edge; simultaneous write and dirty_clr SHALL leave only dirty[op1] set.
REQ-025 Exactly one register SHALL change per write; no other register disturbed, including when op2/op3 equal op1.

Reset
REQ-026 rst_n=0 SHALL immediately, without clk, set every register to RESET_VALUE, dirty to 0, wb_ack to 0, carry to 0.
REQ-027 A write coinciding with reset assertion SHALL be discarded; first write after deassertion SHALL take effect on first rising clk with rst_n=1.
REQ-028 Reset asserted mid-sequence SHALL abort pending wb_ack pulse.

Configuration
REQ-029 Macro MCPU_REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-030 Defined: when regsetwb=1, any read port whose address equals op1 SHALL combinationally show the value being written this cycle.
REQ-031 Undefined: read ports SHALL show the pre-write value until the writing edge (read-before-write).

Verification
REQ-032 Reset then read all 16 addresses -> all 0x0000, dirty=0x0000, wb_ack=0, carry=0.
REQ-033 Loop i=0..15: op1=i, regsetcmd=00, datatoload=0x000F, regsetwb=1, then read via op2/op3 -> every register 0x000F, dirty=0xFFFF, wb_ack high throughout.
REQ-034 r3=0xFFFF then regsetcmd=10 on r3 -> r3=0x0000, carry=1; regsetcmd=11 with datatoload=0x0005 -> r3=0x0005, carry=0.
REQ-035 Write 0x1234 to r5 with op2=5 -> alu1=0x1234 same cycle with MCPU_REGFILE_BYPASS_EN, old value until edge without.
REQ-036 dirty_clr=1 together with write to r7 -> dirty=0x0080 next cycle.
REQ-037 Drop rst_n mid-clock after loading r2=0xABCD -> r2=0x0000, wb_ack=0 immediately, before next clk edge.

Source files
------------

// File: rtl/mcpu_registerfile_mp.sv
// mcpu_registerfile_mp: register file with three combinational read ports
// and one write port that performs the command given by regsetcmd.
// When the MCPU_REGFILE_BYPASS_EN macro is defined, a write is forwarded to
// the read ports combinationally. Without it, a read returns the old value
// until the writing edge.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   op1/op2/op3        write address (also the regop read address), alu1 and alu2 read addresses
//   datatoload         write operand
//   regsetwb/regsetcmd write strobe; command 00 load, 01 clear, 10 increment, 11 accumulate
//   dirty_clr          clears the dirty mask
//   regop/alu1/alu2    read data for op1/op2/op3
//   dirty              mask of the registers written since the last clear
//   wb_ack             set for one cycle after each write
//   carry              carry-out of the last arithmetic write
module mcpu_registerfile_mp #(
    parameter int unsigned WORD_SIZE         = 16,
    parameter int unsigned REGS_NUMBER_WIDTH = 4,
    localparam int unsigned REGISTERS_NUMBER = 1 << REGS_NUMBER_WIDTH,
    parameter logic [WORD_SIZE-1:0] RESET_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [REGS_NUMBER_WIDTH-1:0] op1,
    input  logic [REGS_NUMBER_WIDTH-1:0] op2,
    input  logic [REGS_NUMBER_WIDTH-1:0] op3,
    input  logic [WORD_SIZE-1:0]         datatoload,
    input  logic                         regsetwb,
    input  logic [1:0]                   regsetcmd,
    input  logic                         dirty_clr,
    output logic [WORD_SIZE-1:0]         regop,
    output logic [WORD_SIZE-1:0]         alu1,
    output logic [WORD_SIZE-1:0]         alu2,
    output logic [REGISTERS_NUMBER-1:0]  dirty,
    output logic                         wb_ack,
    output logic                         carry
);

    localparam int unsigned SUM_W = WORD_SIZE + 1;

    logic [WORD_SIZE-1:0]        regs [REGISTERS_NUMBER];
    logic [SUM_W-1:0]            sum_c;
    logic [WORD_SIZE-1:0]        wr_data_c;
    logic                        wr_carry_c;
    logic [REGISTERS_NUMBER-1:0] dirty_next_c;

    // Compute the write result for the current command. The sum is one bit wider than a word so that it keeps the carry.
    always_comb begin
        sum_c      = '0;
        wr_data_c  = datatoload;
        wr_carry_c = 1'b0;
        case (regsetcmd)
            2'b00: wr_data_c = datatoload;
            2'b01: wr_data_c = '0;
            2'b10: begin
                sum_c      = {1'b0, regs[op1]} + SUM_W'(1);
                wr_data_c  = sum_c[WORD_SIZE-1:0];
                wr_carry_c = sum_c[WORD_SIZE];
            end
            default: begin
                sum_c      = {1'b0, regs[op1]} + {1'b0, datatoload};
                wr_data_c  = sum_c[WORD_SIZE-1:0];
                wr_carry_c = sum_c[WORD_SIZE];
            end
        endcase
    end

    // A clear takes effect first and the write's own bit goes on top, so that bit survives a simultaneous clear.
    always_comb begin
        dirty_next_c = dirty_clr ? '0 : dirty;
        if (regsetwb) begin
            dirty_next_c[op1] = 1'b1;
        end
    end

    // Read ports, with optional write forwarding
    always_comb begin
        regop = regs[op1];
        alu1  = regs[op2];
        alu2  = regs[op3];
`ifdef MCPU_REGFILE_BYPASS_EN
        if (regsetwb) begin
            regop = wr_data_c;
            if (op2 == op1) alu1 = wr_data_c;
            if (op3 == op1) alu2 = wr_data_c;
        end
`endif
    end

    // Register array and status state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(REGISTERS_NUMBER); i++) begin
                regs[i] <= RESET_VALUE;
            end
            dirty  <= '0;
            wb_ack <= 1'b0;
            carry  <= 1'b0;
        end else begin
            dirty  <= dirty_next_c;
            wb_ack <= regsetwb;
            if (regsetwb) begin
                regs[op1] <= wr_data_c;
                carry     <= wr_carry_c;
            end
        end
    end

endmodule
